mem_line_responder: RTL and testbench

- Memory-side responder for the cache-controller refill interface.
- Samples a line request from the cache controller and waits a fixed latency.
- Then streams one cache line as 2**WORD_OFFSET single-word beats, each qualified by ack_mem2cc.
- Backed by an internal synchronous word RAM, preloadable through a side port; serves as the synthesizable main memory behind the cache.

---
 rtl/mem_line_pkg.sv | 24 ++
 rtl/mem_word_ram.sv | 35 +++
 rtl/mem_line_responder.sv | 120 ++++++++++++
 tb/tb_mem_line_responder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_pkg.sv
// Shared types and helpers for the memory-side line refill responder.
package mem_line_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DRAIN
    } state_t;

    localparam int unsigned WORD_OFFSET_DEFAULT = 2;
    localparam int unsigned BEATS = 1 << WORD_OFFSET_DEFAULT;

    // Word index of beat k: stays inside the line of base, wrapping from start.
    function automatic logic [31:0] line_word(input logic [31:0] base,
                                              input logic [31:0] start,
                                              input logic [31:0] k,
                                              input int unsigned wo);
        logic [31:0] mask;
        mask = (32'd1 << wo) - 32'd1;
        return (base & ~mask) | ((start + k) & mask);
    endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Synchronous word RAM: one preload write port, one registered read-first read port.
module mem_word_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [MEM_AW-1:0]     wadr,
    input  logic [DATA_WIDTH-1:0] wdat,
    input  logic                  re,
    input  logic [MEM_AW-1:0]     radr,
    output logic [DATA_WIDTH-1:0] rdat
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wadr] <= wdat;
        end
    end

    // Only the read register is reset; array contents are left untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat <= '0;
        end else if (re) begin
            rdat <= mem[radr];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line refill responder backed by a preloadable word RAM.
// Optional critical-word-first beat order: MEM_CRITICAL_WORD_FIRST_EN.
module mem_line_responder
    import mem_line_pkg::*;
#(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WORD_OFFSET = 2,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned LATENCY     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc2mem,
    input  logic [ADR_WIDTH-1:0]  adr_cc2mem,
    output logic                  ack_mem2cc,
    output logic [DATA_WIDTH-1:0] dat_mem2cc,
    input  logic                  ld_we,
    input  logic [MEM_AW-1:0]     ld_adr,
    input  logic [DATA_WIDTH-1:0] ld_dat,
    output logic                  busy
);

    state_t                 state, state_nx;
    logic [7:0]             wait_cnt, wait_cnt_nx;
    logic [WORD_OFFSET-1:0] beat, beat_nx;
    logic [MEM_AW-1:0]      idx_q, idx_nx;
    logic                   ack_nx;
    logic                   rd_en;
    logic [WORD_OFFSET-1:0] start;
    logic [31:0]            rd_word;
    logic [MEM_AW-1:0]      rd_adr;
    logic                   unused_bits;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign start = idx_q[WORD_OFFSET-1:0];
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            beat       <= '0;
            idx_q      <= '0;
            ack_mem2cc <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_cnt_nx;
            beat       <= beat_nx;
            idx_q      <= idx_nx;
            ack_mem2cc <= ack_nx;
        end
    end

    // The RAM is read on the edge that raises ack, so each beat's data and
    // its ack become visible together.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        beat_nx     = beat;
        idx_nx      = idx_q;
        ack_nx      = 1'b0;
        rd_en       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_cc2mem) begin
                    state_nx    = WAIT;
                    wait_cnt_nx = 8'(LATENCY - 1);
                    idx_nx      = adr_cc2mem[MEM_AW+1:2];
                    beat_nx     = '0;
                end
            end
            WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_nx = BURST;
                end else begin
                    wait_cnt_nx = wait_cnt - 8'd1;
                end
            end
            BURST: begin
                rd_en   = 1'b1;
                ack_nx  = 1'b1;
                beat_nx = beat + WORD_OFFSET'(1);
                if (&beat) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!req_cc2mem) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_word = line_word(32'(idx_q), 32'(start), 32'(beat), WORD_OFFSET);
    assign rd_adr  = rd_word[MEM_AW-1:0];
    assign busy    = (state != IDLE);

    assign unused_bits = ^{adr_cc2mem[1:0], adr_cc2mem[ADR_WIDTH-1:MEM_AW+2],
                           rd_word[31:MEM_AW]};

    mem_word_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_AW    (MEM_AW)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (ld_we),
        .wadr(ld_adr),
        .wdat(ld_dat),
        .re  (rd_en),
        .radr(rd_adr),
        .rdat(dat_mem2cc)
    );

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench: timeline reference model plus directed literal checks.
module tb_mem_line_responder;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned WO  = 2;
    localparam int unsigned MAW = 10;
    localparam int unsigned LAT = 3;
    localparam int unsigned NB  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic [AW-1:0]  adr;
    logic           ack;
    logic [DW-1:0]  dat;
    logic           ld_we;
    logic [MAW-1:0] ld_adr;
    logic [DW-1:0]  ld_dat;
    logic           busy;

    always #5 clk = ~clk;

    mem_line_responder #(
        .ADR_WIDTH  (AW),
        .DATA_WIDTH (DW),
        .WORD_OFFSET(WO),
        .MEM_AW     (MAW),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_cc2mem(req),
        .adr_cc2mem(adr),
        .ack_mem2cc(ack),
        .dat_mem2cc(dat),
        .ld_we     (ld_we),
        .ld_adr    (ld_adr),
        .ld_dat    (ld_dat),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image plus the request timeline.
    logic [DW-1:0] mem_m [1024];
    bit            m_busy  = 1'b0;
    longint        m_t     = 0;
    logic [AW-1:0] m_adr   = '0;
    bit            exp_ack = 1'b0;
    logic [DW-1:0] exp_dat = '0;
    longint        cyc     = 0;

    function automatic int unsigned widx(input logic [AW-1:0] a, input int unsigned k);
        int unsigned idx, base, st;
        idx  = int'(a[MAW+1:2]);
        base = (idx / NB) * NB;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
        st = idx % NB;
`else
        st = 0;
`endif
        return base + ((st + k) % NB);
    endfunction

    initial begin : compare
        longint d;
        forever begin
            @(posedge clk);
            cyc++;
            exp_ack = 1'b0;
            if (rst) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (req) begin
                    m_busy = 1'b1;
                    m_t    = cyc;
                    m_adr  = adr;
                end
            end else begin
                d = cyc - m_t - longint'(LAT) - 1;
                if (d >= 0 && d < longint'(NB)) begin
                    exp_ack = 1'b1;
                    exp_dat = mem_m[widx(m_adr, int'(d))];
                end else if (d >= longint'(NB) && !req) begin
                    m_busy = 1'b0;
                end
            end
            if (ld_we) mem_m[ld_adr] = ld_dat;
            #1;
            chk("model_ack", ack, exp_ack);
            chk("model_busy", busy, m_busy);
            if (exp_ack) chk("model_dat", dat, exp_dat);
        end
    end

    task automatic load(input int unsigned a, input logic [DW-1:0] v);
        @(negedge clk);
        ld_we  = 1'b1;
        ld_adr = MAW'(a);
        ld_dat = v;
        @(negedge clk);
        ld_we  = 1'b0;
    endtask

    task automatic load_line_a;
        for (int unsigned i = 0; i < NB; i++) load(32'h340 + i, 32'hA0 + i);
    endtask

    task automatic collect(input int win, output int n, output logic [DW-1:0] b [4]);
        n = 0;
        for (int i = 0; i < 4; i++) b[i] = '0;
        for (int i = 0; i < win; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                if (n < 4) b[n] = dat;
                n++;
            end
        end
    endtask

    // Issues a request at 0xD00, waits for beat 0, then writes one word.
    task automatic collide(input int unsigned wa, input logic [DW-1:0] wv,
                           output int n, output logic [DW-1:0] b [4]);
        int k;
        n = 0;
        k = 0;
        for (int i = 0; i < 4; i++) b[i] = '0;
        @(negedge clk);
        req = 1'b1;
        adr = 32'h0000_0D00;
        while (!ack && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("collide_first_beat", ack, 1'b1);
        b[0] = dat;
        n    = 1;
        ld_we  = 1'b1;
        ld_adr = MAW'(wa);
        ld_dat = wv;
        req    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ld_we = 1'b0;
            if (ack) begin
                if (n < 4) b[n] = dat;
                n++;
            end
        end
    endtask

    initial begin : stim
        int            n, seen, k, ord;
        logic [DW-1:0] b [4];

        rst    = 1'b1;
        req    = 1'b0;
        adr    = '0;
        ld_we  = 1'b0;
        ld_adr = '0;
        ld_dat = '0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_ack", ack, 1'b0);
            chk("reset_busy", busy, 1'b0);
            chk("reset_dat", dat, 32'h0);
        end
        rst = 1'b0;

        @(negedge clk);
        ld_we = 1'b1;
        for (int unsigned i = 0; i < 1024; i++) begin
            ld_adr = MAW'(i);
            ld_dat = $urandom;
            @(negedge clk);
        end
        ld_we = 1'b0;
        load_line_a();

        // Basic line: request sampled at edge T, beats in T+4..T+7.
        @(negedge clk);
        req = 1'b1;
        adr = 32'h0000_0D00;
        @(posedge clk);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            chk("basic_ack", ack, (j >= 4 && j <= 7));
            if (j >= 4 && j <= 7) chk("basic_dat", dat, 32'hA0 + j - 4);
            if (j == 7) chk("basic_busy_hi", busy, 1'b1);
            if (j == 8) chk("basic_busy_lo", busy, 1'b0);
            if (j == 2) req = 1'b0;
        end

        // Missed word at offset 2.
        @(negedge clk);
        req = 1'b1;
        adr = 32'h0000_0D08;
        @(posedge clk);
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk);
            #1;
            chk("cwf_ack", ack, (j >= 4 && j <= 7));
`ifdef MEM_CRITICAL_WORD_FIRST_EN
            ord = (2 + j - 4) % 4;
`else
            ord = j - 4;
`endif
            if (j >= 4 && j <= 7) chk("cwf_dat", dat, 32'hA0 + ord);
            if (j == 1) req = 1'b0;
        end

        // Held request is served once; one low cycle re-arms it.
        @(negedge clk);
        req = 1'b1;
        adr = 32'h0000_0D00;
        collect(30, n, b);
        chk("held_acks", n, 4);
        chk("held_busy", busy, 1'b1);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        collect(15, n, b);
        chk("rearm_acks", n, 4);
        chk("rearm_dat0", b[0], 32'hA0);
        chk("rearm_dat3", b[3], 32'hA3);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after two beats drops ack immediately.
        req  = 1'b1;
        adr  = 32'h0000_0D00;
        seen = 0;
        k    = 0;
        while (seen < 2 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (ack) seen++;
        end
        chk("mid_seen", seen, 2);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        collect(10, n, b);
        chk("mid_no_more", n, 0);
        @(negedge clk);
        req = 1'b1;
        collect(12, n, b);
        chk("mid_next_acks", n, 4);
        chk("mid_next_dat2", b[2], 32'hA2);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Preload write to a later beat of the current line.
        collide(32'h343, 32'h55, n, b);
        chk("coll_later_n", n, 4);
        chk("coll_later_b0", b[0], 32'hA0);
        chk("coll_later_b3", b[3], 32'h55);
        repeat (2) @(negedge clk);
        load(32'h343, 32'hA3);

        // Preload write to the word being read that cycle: old data.
        collide(32'h341, 32'h66, n, b);
        chk("coll_same_n", n, 4);
        chk("coll_same_b1", b[1], 32'hA1);
        chk("coll_same_b3", b[3], 32'hA3);
        repeat (2) @(negedge clk);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) req = ~req;
            adr   = {$urandom} & 32'h0000_1FFF;
            ld_we = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0)
                ld_adr = MAW'(m_adr[MAW+1:2] ^ MAW'($urandom_range(0, 3)));
            else
                ld_adr = MAW'($urandom);
            ld_dat = $urandom;
        end
        @(negedge clk);
        rst   = 1'b0;
        req   = 1'b0;
        ld_we = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
